sequence_gen: RTL and testbench
===============================

# sequence_gen

Serial pattern transmitter: on a start request it captures a PAT_W-bit pattern and drives it MSB-first onto a one-bit serial line, repeated a programmable number of times with a programmable idle gap between repetitions. It is the stimulus/transmit end of the serial-sequence path. Its `x` output connects directly to the `x` input of the team's sequence detectors, so a detector sees the programmed pattern once per repetition.

## Interface
- PAT_W, default 6: pattern length in bits (≥2).
- CNT_W, default 4: width of the repetition and gap counts.
- PATTERN_DEFAULT, default 6'b101101: value held in the pattern register after reset (package constant).

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset). Deassertion is synchronous to clk (synchronised externally).
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send; bit PAT_W-1 is sent first.
- reps  in  CNT_W  number of repetitions, 1..2^CNT_W-1. A value of 0 makes start ignored.
- gap  in  CNT_W  idle cycles between repetitions, 0..2^CNT_W-1.
- x  out  1  serial data.
- x_valid  out  1  high while x carries a pattern bit.
- busy  out  1  high from the first SEND cycle through the DONE cycle.
- done  out  1  one-cycle pulse after the final bit.

## Operation
- All outputs are registered (Moore); none depends combinationally on inputs.
- Reset values: x=0, x_valid=0, busy=0, done=0, state=IDLE, pattern register=PATTERN_DEFAULT, counters=0.
- States:
  - IDLE: outputs 0. On start=1 and reps≠0, capture pattern, reps and gap, then go to SEND. start with reps=0 causes no state change.
  - SEND: x = shift-register MSB, x_valid=1, busy=1. The shift register moves left one bit per cycle and the bit counter counts PAT_W-1 down to 0. After the bit-0 cycle, the repetition counter decrements:
    - remaining=0 → DONE.
    - remaining>0 and gap=0 → SEND, with the shift register reloaded from the captured pattern.
    - remaining>0 and gap>0 → GAP.
  - GAP: x=0, x_valid=0, busy=1 for exactly gap cycles. Then SEND with the shift register reloaded.
  - DONE: done=1, busy=1, x=0, x_valid=0 for one cycle, then IDLE.
- start is ignored in SEND, GAP and DONE. Input changes after capture do not affect the transfer in progress.
- Counters never wrap; an illegal state encoding goes to IDLE with outputs 0.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronously) and the transfer is abandoned. After release the block is in IDLE and no done pulse is issued.

## Timing
- start sampled high at edge N (in IDLE) → first bit on x in cycle N+1.
- Repetition r (0-based) occupies SEND cycles N+1+r·(PAT_W+gap) through N+r·(PAT_W+gap)+PAT_W.
- done is high in cycle N+1+reps·PAT_W+(reps-1)·gap. IDLE follows in the next cycle, and the earliest new start is sampled at the end of that cycle.
- Back-to-back repetitions with gap=0 produce a continuous x_valid=1 stream of reps·PAT_W cycles.
- Throughput: one bit per cycle; no backpressure.

## Structure
- Package seq_pkg holds:
  - the state enum typedef (IDLE, SEND, GAP, DONE) as 2-bit logic,
  - the PATTERN_DEFAULT constant,
  - the default PAT_W and CNT_W constants, shared with the detector benches.
- One sub-module, seq_down_counter: loadable down-counter with a zero flag and parameterised width. It is instantiated three times, for the bit index, the repetition count and the gap count.
- The top level holds the FSM, the shift register and the output registers.

## Test plan
- Reset: hold rst=0 with start=1 → x=0, x_valid=0, busy=0, done=0 throughout. Assert rst=0 during SEND → all outputs 0 in the same cycle, IDLE after release, no done.
- Single shot: pattern=6'b101101, reps=1, gap=0 → x = 1,0,1,1,0,1 in cycles N+1..N+6 with x_valid=1; done=1 in N+7; busy high N+1..N+7. A sequence_det driven by x (active-high rst tied inactive) pulses y once.
- Repeat with gap: pattern=6'b110010, reps=3, gap=2 → three 6-bit bursts separated by 2 cycles of x=0/x_valid=0; done in cycle N+23.
- Continuous: pattern=6'b101101, reps=2, gap=0 → 12 consecutive valid bits 101101101101; done in N+13.
- Ignored requests: start with reps=0 → no busy. start re-pulsed during SEND with a different pattern → the output stream is unchanged.
- Boundary: reps=15, gap=15, PAT_W=6 → done at N+1+90+210 = N+301; no counter wrap; then IDLE, and a new start is accepted in the following cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter and its detector benches.
package seq_pkg;

   localparam int unsigned DEF_PAT_W = 6;
   localparam int unsigned DEF_CNT_W = 4;
   localparam logic [DEF_PAT_W-1:0] PATTERN_DEFAULT = 6'b101101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and it never wraps below zero.
module seq_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && !zero_c) begin
         count_d = count_q - W'(1);
      end
   end

   assign zero_c = (count_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, reps times, with gap idle cycles between.
module sequence_gen
   import seq_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic [CNT_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BIT_W = $clog2(PAT_W);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] gap_len_q, gap_len_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             bit_load, bit_dec, bit_zero;
   logic             rep_load, rep_dec, rep_zero;
   logic             gap_load, gap_dec, gap_zero;
   logic [CNT_W-1:0] rep_load_val;
   logic [CNT_W-1:0] gap_load_val;

   // Repetition counter holds "repetitions still to go after this one"; gap counter holds cycles left minus one.
   assign rep_load_val = reps - CNT_W'(1);
   assign gap_load_val = gap_len_q - CNT_W'(1);

   seq_down_counter #(.W(BIT_W)) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .load     (bit_load),
      .load_val (BIT_W'(PAT_W - 1)),
      .dec      (bit_dec),
      .zero_c   (bit_zero)
   );

   seq_down_counter #(.W(CNT_W)) u_rep_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .load     (rep_load),
      .load_val (rep_load_val),
      .dec      (rep_dec),
      .zero_c   (rep_zero)
   );

   seq_down_counter #(.W(CNT_W)) u_gap_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .load     (gap_load),
      .load_val (gap_load_val),
      .dec      (gap_dec),
      .zero_c   (gap_zero)
   );

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      sh_d      = sh_q;
      gap_len_d = gap_len_q;
      bit_load  = 1'b0;
      bit_dec   = 1'b0;
      rep_load  = 1'b0;
      rep_dec   = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (reps != '0)) begin
               state_d   = SEND;
               pat_d     = pattern;
               sh_d      = pattern;
               gap_len_d = gap;
               bit_load  = 1'b1;
               rep_load  = 1'b1;
            end
         end
         SEND: begin
            if (!bit_zero) begin
               sh_d    = sh_q << 1;
               bit_dec = 1'b1;
            end else if (rep_zero) begin
               state_d = DONE;
            end else begin
               rep_dec = 1'b1;
               if (gap_len_q == '0) begin
                  sh_d     = pat_q;
                  bit_load = 1'b1;
               end else begin
                  state_d  = GAP;
                  gap_load = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_zero) begin
               state_d  = SEND;
               sh_d     = pat_q;
               bit_load = 1'b1;
            end else begin
               gap_dec = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so the registered copies line up with the state they describe.
      x_valid_d = (state_d == SEND);
      x_d       = x_valid_d & sh_d[PAT_W-1];
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pat_q     <= PAT_W'(PATTERN_DEFAULT);
         sh_q      <= PAT_W'(PATTERN_DEFAULT);
         gap_len_q <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         sh_q      <= sh_d;
         gap_len_q <= gap_len_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sequence_gen.sv
// Scoreboard bench for sequence_gen: stimulus pushes the expected serial stream, a negedge monitor checks it.
module tb_sequence_gen;

   localparam int unsigned PAT_W = 6;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] reps;
   logic [CNT_W-1:0] gap;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic             done;

   typedef struct {
      int   cyc;
      logic b;
   } exp_bit_t;

   exp_bit_t exp_q[$];
   int       done_q[$];
   int       busy_lo = 0;
   int       busy_hi = -1;
   int       cyc = 0;
   int       errors = 0;
   int       checks = 0;

   sequence_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pattern (pattern),
      .reps    (reps),
      .gap     (gap),
      .x       (x),
      .x_valid (x_valid),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: first bit one cycle after the sampling edge, bursts spaced PAT_W+gap apart.
   task automatic issue(input logic [PAT_W-1:0] p, input int r, input int g);
      int s;
      s       = cyc + 1;
      start   = 1'b1;
      pattern = p;
      reps    = CNT_W'(r);
      gap     = CNT_W'(g);
      if (r != 0) begin
         for (int k = 0; k < r; k++) begin
            for (int i = 0; i < int'(PAT_W); i++) begin
               exp_q.push_back('{cyc: s + k * (int'(PAT_W) + g) + i, b: p[int'(PAT_W) - 1 - i]});
            end
         end
         done_q.push_back(s + r * int'(PAT_W) + (r - 1) * g);
         busy_lo = s;
         busy_hi = s + r * int'(PAT_W) + (r - 1) * g;
      end
      @(negedge clk);
      start   = 1'b0;
      pattern = PAT_W'($urandom);
      reps    = CNT_W'($urandom);
      gap     = CNT_W'($urandom);
   endtask

   task automatic wait_done(input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout at cycle %0d: got no done within %0d cycles", cyc, limit);
      end
      @(negedge clk);
   endtask

   // Monitor: compares every cycle against the scoreboard queues and busy window.
   always @(negedge clk) begin
      logic exp_v, exp_d, exp_b;
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("x_valid", int'(x_valid), int'(exp_v));
      if (exp_v) begin
         if (x_valid) chk("x_bit", int'(x), int'(exp_q[0].b));
         void'(exp_q.pop_front());
      end else if (!x_valid) begin
         chk("x_idle", int'(x), 0);
      end
      exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", int'(done), int'(exp_d));
      if (exp_d) void'(done_q.pop_front());
      exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", int'(busy), int'(exp_b));
   end

   initial begin
      rst     = 1'b0;
      start   = 1'b1;
      pattern = 6'b111111;
      reps    = 4'd3;
      gap     = 4'd1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);

      issue(6'b101101, 1, 0);
      wait_done(40);

      issue(6'b110010, 3, 2);
      wait_done(60);

      issue(6'b101101, 2, 0);
      wait_done(40);

      // A start held high with reps=0 must be ignored.
      start   = 1'b1;
      pattern = 6'b111000;
      reps    = 4'd0;
      gap     = 4'd3;
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(negedge clk);

      // Re-pulsing start mid-transfer with new inputs must not disturb the stream.
      issue(6'b100111, 2, 1);
      repeat (2) @(negedge clk);
      start   = 1'b1;
      pattern = 6'b011000;
      reps    = 4'd5;
      gap     = 4'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done(60);

      issue(6'b110101, 15, 15);
      wait_done(400);
      issue(6'b010011, 1, 0);
      wait_done(40);

      // Asynchronous reset in the middle of SEND abandons the transfer.
      issue(6'b111011, 3, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      done_q.delete();
      busy_hi = -1;
      #1;
      chk("rst_x", int'(x), 0);
      chk("rst_x_valid", int'(x_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int t = 0; t < 10; t++) begin
         int r, g;
         r = int'($urandom_range(0, 4));
         g = int'($urandom_range(0, 3));
         if (r == 0) begin
            issue(PAT_W'($urandom), 0, g);
            @(negedge clk);
         end else begin
            issue(PAT_W'($urandom), r, g);
            wait_done(120);
         end
      end

      repeat (4) @(negedge clk);
      chk("bits_left", exp_q.size(), 0);
      chk("done_left", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
